// File: rtl/priority_encoder_rr_if.sv
// Request/result handshake bundle for priority_encoder_rr.
// master = upstream producer plus downstream consumer; slave = the encoder.
interface priority_encoder_rr_if #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_zero;
    logic         out_multi;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  out_zero,
        input  out_multi
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output out_zero,
        output out_multi
    );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with one-deep result stage; fixed-priority (highest index)
// or round-robin (lowest index after the last grant) selection.
module priority_encoder_rr #(
    parameter int unsigned N  = 16,
    parameter int unsigned W  = 4,
    parameter int unsigned RR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    priority_encoder_rr_if.slave bus
);

    localparam int unsigned PTR_RST = N - 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         accept_c;
    logic         in_ready_c;

    logic [W-1:0] ptr_q;
    logic [W-1:0] out_idx_q;
    logic [N-1:0] out_onehot_q;
    logic         out_zero_q;
    logic         out_multi_q;

    logic [W-1:0] fp_idx;
    logic [W-1:0] lo_idx;
    logic [W-1:0] hi_idx;
    logic         lo_found;
    logic         hi_found;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_onehot;
    logic         vec_zero;
    logic         vec_multi;

    // Ready is forced low while reset is held so nothing presented then is taken.
    assign in_ready_c = rst_n && ((state_q == S_EMPTY) || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Single pass gives highest set bit, lowest set bit, and lowest set bit above ptr.
    always_comb begin
        fp_idx   = '0;
        lo_idx   = '0;
        hi_idx   = '0;
        lo_found = 1'b0;
        hi_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.in_vec[i]) begin
                fp_idx = W'(i);
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = W'(i);
                end
                if (!hi_found && (W'(i) > ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = W'(i);
                end
            end
        end
    end

    always_comb begin
        win_idx = '0;
        if (RR == 0) begin
            win_idx = fp_idx;
        end else if (hi_found) begin
            win_idx = hi_idx;
        end else begin
            win_idx = lo_idx;
        end
    end

    // Clearing the lowest set bit leaves something behind iff two or more bits were set.
    assign vec_zero   = (bus.in_vec == '0);
    assign vec_multi  = |(bus.in_vec & (bus.in_vec - N'(1)));
    assign win_onehot = vec_zero ? '0 : (N'(1) << win_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A new accept always refills the stage, so consume+accept is back-to-back.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            state_d = S_FULL;
        end else if (bus.out_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_zero_q   <= 1'b0;
            out_multi_q  <= 1'b0;
        end else if (accept_c) begin
            out_idx_q    <= win_idx;
            out_onehot_q <= win_onehot;
            out_zero_q   <= vec_zero;
            out_multi_q  <= vec_multi;
        end
    end

    // Empty vectors carry no grant, so the round-robin position is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= W'(PTR_RST);
        end else if (accept_c && !vec_zero) begin
            ptr_q <= win_idx;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (state_q == S_FULL);
    assign bus.out_idx    = out_idx_q;
    assign bus.out_onehot = out_onehot_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_multi  = out_multi_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three instances (N16 fixed, N16 round-robin, N10 round-robin)
// checked by a model-fed scoreboard plus directed spot checks.
module tb_priority_encoder_rr;

    typedef struct packed {
        logic [5:0]  idx;
        logic [63:0] oh;
        logic        zero;
        logic        multi;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        iv   [3];
    logic        ordy [3];
    logic [63:0] vec  [3];

    logic        ov     [3];
    logic        rdy_in [3];
    logic [5:0]  idx_a  [3];
    logic [63:0] oh_a   [3];
    logic        zero_a [3];
    logic        multi_a[3];

    int n_vec = 0;
    int n_err = 0;

    res_t q0[$];
    res_t q1[$];
    res_t q2[$];
    logic mvalid[3];
    int   ptr_m [3];

    priority_encoder_rr_if #(.N(16), .W(4)) if0 ();
    priority_encoder_rr_if #(.N(16), .W(4)) if1 ();
    priority_encoder_rr_if #(.N(10), .W(4)) if2 ();

    priority_encoder_rr #(.N(16), .W(4), .RR(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    priority_encoder_rr #(.N(16), .W(4), .RR(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    priority_encoder_rr #(.N(10), .W(4), .RR(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid = iv[0];  assign if0.in_vec = vec[0][15:0]; assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];  assign if1.in_vec = vec[1][15:0]; assign if1.out_ready = ordy[1];
    assign if2.in_valid = iv[2];  assign if2.in_vec = vec[2][9:0];  assign if2.out_ready = ordy[2];

    assign ov[0] = if0.out_valid; assign rdy_in[0] = if0.in_ready; assign idx_a[0] = 6'(if0.out_idx);
    assign oh_a[0] = 64'(if0.out_onehot); assign zero_a[0] = if0.out_zero; assign multi_a[0] = if0.out_multi;
    assign ov[1] = if1.out_valid; assign rdy_in[1] = if1.in_ready; assign idx_a[1] = 6'(if1.out_idx);
    assign oh_a[1] = 64'(if1.out_onehot); assign zero_a[1] = if1.out_zero; assign multi_a[1] = if1.out_multi;
    assign ov[2] = if2.out_valid; assign rdy_in[2] = if2.in_ready; assign idx_a[2] = 6'(if2.out_idx);
    assign oh_a[2] = 64'(if2.out_onehot); assign zero_a[2] = if2.out_zero; assign multi_a[2] = if2.out_multi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nn(input int k);
        return (k == 2) ? 10 : 16;
    endfunction

    function automatic int rrm(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic logic [63:0] vmask(input int n);
        logic [63:0] m;
        m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        return m;
    endfunction

    // Reference: count bits, then pick winner by straightforward scans.
    function automatic res_t predict(input int n, input int rr, input logic [63:0] v, input int p);
        res_t r;
        int   cnt;
        int   win;
        r   = '0;
        cnt = 0;
        win = -1;
        for (int i = 0; i < n; i++) if (v[i]) cnt++;
        if (rr == 0) begin
            for (int i = 0; i < n; i++) if (v[i]) win = i;
        end else begin
            for (int i = p + 1; i < n; i++) if (v[i] && win < 0) win = i;
            for (int i = 0; i < n; i++) if (v[i] && win < 0) win = i;
        end
        r.zero  = (cnt == 0);
        r.multi = (cnt >= 2);
        if (win >= 0) begin
            r.idx = 6'(win);
            r.oh  = 64'd1 << win;
        end
        return r;
    endfunction

    task automatic q_push(input int k, input res_t r);
        case (k)
            0: q0.push_back(r);
            1: q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic q_pop(input int k);
        case (k)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic res_t q_head(input int k);
        case (k)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    // Scoreboard: model handshake, check held result, pop on consume, push on accept.
    always @(negedge clk) begin
        res_t e;
        logic exp_rdy;
        logic acc;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mvalid[k] = 1'b0;
                ptr_m[k]  = nn(k) - 1;
                q_clear(k);
                chk($sformatf("u%0d.rst_out_valid", k), 64'(ov[k]), 64'd0);
                chk($sformatf("u%0d.rst_in_ready", k), 64'(rdy_in[k]), 64'd0);
            end else begin
                exp_rdy = !mvalid[k] || ordy[k];
                chk($sformatf("u%0d.in_ready", k), 64'(rdy_in[k]), 64'(exp_rdy));
                chk($sformatf("u%0d.out_valid", k), 64'(ov[k]), 64'(mvalid[k]));
                if (mvalid[k] && q_size(k) > 0) begin
                    e = q_head(k);
                    chk($sformatf("u%0d.idx", k), 64'(idx_a[k]), 64'(e.idx));
                    chk($sformatf("u%0d.onehot", k), oh_a[k], e.oh);
                    chk($sformatf("u%0d.zero", k), 64'(zero_a[k]), 64'(e.zero));
                    chk($sformatf("u%0d.multi", k), 64'(multi_a[k]), 64'(e.multi));
                    if (ordy[k]) q_pop(k);
                end
                acc = iv[k] && exp_rdy;
                if (acc) begin
                    e = predict(nn(k), rrm(k), vec[k] & vmask(nn(k)), ptr_m[k]);
                    q_push(k, e);
                    if (!e.zero) ptr_m[k] = int'(e.idx);
                end
                mvalid[k] = acc ? 1'b1 : (ordy[k] ? 1'b0 : mvalid[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input int k, input int idx, input logic [63:0] oh, input logic z, input logic m);
        chk($sformatf("u%0d.d_valid", k), 64'(ov[k]), 64'd1);
        chk($sformatf("u%0d.d_idx", k), 64'(idx_a[k]), 64'(idx));
        chk($sformatf("u%0d.d_onehot", k), oh_a[k], oh);
        chk($sformatf("u%0d.d_zero", k), 64'(zero_a[k]), 64'(z));
        chk($sformatf("u%0d.d_multi", k), 64'(multi_a[k]), 64'(m));
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            vec[k]  = '0;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_all();
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk_res_reset: begin
            chk($sformatf("u%0d.r_valid", k), 64'(ov[k]), 64'd0);
            chk($sformatf("u%0d.r_idx", k), 64'(idx_a[k]), 64'd0);
            chk($sformatf("u%0d.r_onehot", k), oh_a[k], 64'd0);
            chk($sformatf("u%0d.r_zero", k), 64'(zero_a[k]), 64'd0);
            chk($sformatf("u%0d.r_multi", k), 64'(multi_a[k]), 64'd0);
            chk($sformatf("u%0d.r_ready", k), 64'(rdy_in[k]), 64'd0);
        end
        repeat (3) cyc();
        rst_n = 1'b1;

        // Fixed priority picks the highest set bit.
        iv[0] = 1'b1; vec[0] = 64'h0A50;
        cyc();
        chk_res(0, 11, 64'h0800, 1'b0, 1'b1);
        iv[0] = 1'b0;

        // Round-robin walk from reset pointer N-1.
        iv[1] = 1'b1; vec[1] = 64'h8101;
        cyc(); chk_res(1, 0,  64'h0001, 1'b0, 1'b1);
        cyc(); chk_res(1, 8,  64'h0100, 1'b0, 1'b1);
        cyc(); chk_res(1, 15, 64'h8000, 1'b0, 1'b1);
        cyc(); chk_res(1, 0,  64'h0001, 1'b0, 1'b1);

        // Zero vector leaves the pointer at 0.
        vec[1] = 64'h0;
        cyc(); chk_res(1, 0, 64'h0, 1'b1, 1'b0);
        vec[1] = 64'h0003;
        cyc(); chk_res(1, 1, 64'h0002, 1'b0, 1'b1);

        // Stall: result held, input blocked, then no-bubble resume.
        vec[1] = 64'h00F0;
        cyc(); chk_res(1, 4, 64'h0010, 1'b0, 1'b1);
        ordy[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vec[1] = 64'($urandom);
            cyc();
            chk("u1.stall_ready", 64'(rdy_in[1]), 64'd0);
            chk_res(1, 4, 64'h0010, 1'b0, 1'b1);
        end
        ordy[1] = 1'b1; vec[1] = 64'h0100;
        #1 chk("u1.resume_ready", 64'(rdy_in[1]), 64'd1);
        cyc(); chk_res(1, 8, 64'h0100, 1'b0, 1'b0);
        iv[1] = 1'b0;

        // Non-power-of-two wrap: pointer 9 -> index 0, then 9.
        iv[2] = 1'b1; vec[2] = 64'h201;
        cyc(); chk_res(2, 0, 64'h001, 1'b0, 1'b1);
        cyc(); chk_res(2, 9, 64'h200, 1'b0, 1'b1);
        iv[2] = 1'b0;
        cyc();

        // Random traffic on all three instances, scoreboard does the checking.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: vec[k] = '0;
                    1: vec[k] = 64'd1 << $urandom_range(0, 15);
                    default: vec[k] = {32'($urandom), 32'($urandom)};
                endcase
            end
            cyc();
        end

        // Reset between edges with a held result, then first vector after release.
        idle_all();
        iv[1] = 1'b1; vec[1] = 64'h0C00; ordy[1] = 1'b0;
        cyc();
        iv[1] = 1'b0;
        cyc();
        chk("u1.pre_rst_valid", 64'(ov[1]), 64'd1);
        #2 rst_n = 1'b0;
        iv[1] = 1'b1; vec[1] = 64'hFFFF;
        #1;
        chk("u1.async_valid", 64'(ov[1]), 64'd0);
        chk("u1.async_ready", 64'(rdy_in[1]), 64'd0);
        cyc();
        cyc();
        chk("u1.in_rst_valid", 64'(ov[1]), 64'd0);
        rst_n = 1'b1; ordy[1] = 1'b1;
        cyc(); chk_res(1, 0, 64'h0001, 1'b0, 1'b1);
        iv[1] = 1'b0;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
